// File: rtl/ov_cam_pkg.sv
// Shared types and constants for the camera capture path: controller states,
// sticky error codes and the default frame geometry.
package ov_cam_pkg;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC_HI = 3'd1,
        ST_SYNC_LO = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_WAIT_WR = 3'd4,
        ST_ABORT   = 3'd5
    } cap_state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LINE  = 2'd1;
    localparam logic [1:0] ERR_SHORT = 2'd2;
    localparam logic [1:0] ERR_LONG  = 2'd3;

    // Byte phase at which luma appears within a YUV422 byte pair.
    function automatic logic lumaPhase(input logic yFirst);
        return ~yFirst;
    endfunction

endpackage

// File: rtl/sig_edge_det.sv
// Registers a single-bit signal and flags its rising/falling edge by comparing
// the live value with the value seen on the previous clock.
module sig_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign level_o = sig_q;
    assign rise_o  = sig_i & ~sig_q;
    assign fall_o  = ~sig_i & sig_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Captures the luma plane of one YUV422 camera frame and streams it to the BMP writer.
// Line and frame length problems are latched in err until the next accepted start.
module frame_capture_ctrl
    import ov_cam_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter bit Y_FIRST = 1'b1
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       start,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    input  logic       write_done,
    output logic       pix_valid,
    output logic [7:0] pix_data,
    output logic       busy,
    output logic       frame_done,
    output logic [1:0] err
);

    localparam int PW = $clog2(WIDTH + 1);
    localparam int LW = $clog2(HEIGHT + 1);
    localparam logic [PW-1:0] PIX_MAX    = PW'(WIDTH);
    localparam logic [LW-1:0] LINE_MAX   = LW'(HEIGHT);
    localparam logic [LW-1:0] LINE_LAST  = LW'(HEIGHT - 1);
    localparam logic          LUMA_PHASE = lumaPhase(Y_FIRST);

    cap_state_e    state_q;
    logic [PW-1:0] pixCnt_q;
    logic [LW-1:0] lineCnt_q;
    logic          phase_q;
    logic          phase_d;
    logic          hrefGated;
    logic          hrefLevel;
    logic          hrefRise;
    logic          hrefFall;
    logic          vsLevel;
    logic          vsRise;
    logic          vsFall;
    logic          lumaNow;
    logic          unusedEdgeBits;

    // Line bytes that arrive while vsync is high belong to no frame.
    assign hrefGated      = cam_href & ~cam_vsync;
    assign phase_d        = hrefGated ? ~phase_q : 1'b0;
    assign lumaNow        = hrefGated & (phase_q == LUMA_PHASE);
    assign unusedEdgeBits = hrefLevel ^ vsLevel ^ vsRise;

    sig_edge_det uHrefEdge (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .sig_i   (hrefGated),
        .level_o (hrefLevel),
        .rise_o  (hrefRise),
        .fall_o  (hrefFall)
    );

    sig_edge_det uVsyncEdge (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .sig_i   (cam_vsync),
        .level_o (vsLevel),
        .rise_o  (vsRise),
        .fall_o  (vsFall)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            pixCnt_q   <= '0;
            lineCnt_q  <= '0;
            phase_q    <= 1'b0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= ERR_NONE;
        end else begin
            phase_q    <= phase_d;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_SYNC_HI;
                        busy      <= 1'b1;
                        err       <= ERR_NONE;
                        pixCnt_q  <= '0;
                        lineCnt_q <= '0;
                    end
                end
                ST_SYNC_HI: begin
                    if (cam_vsync) begin
                        state_q <= ST_SYNC_LO;
                    end
                end
                // vsync was high when we got here, so its fall marks the frame start.
                ST_SYNC_LO: begin
                    if (vsFall) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (cam_vsync && (lineCnt_q < LINE_MAX)) begin
                        err     <= ERR_SHORT;
                        state_q <= ST_ABORT;
                    end else if (lumaNow) begin
                        if ((pixCnt_q < PIX_MAX) && (lineCnt_q < LINE_MAX)) begin
                            pix_valid <= 1'b1;
                            pix_data  <= cam_data;
                            pixCnt_q  <= pixCnt_q + PW'(1);
                        end
                    end else if (hrefFall) begin
                        if ((pixCnt_q != PIX_MAX) && (err == ERR_NONE)) begin
                            err <= ERR_LINE;
                        end
                        pixCnt_q <= '0;
                        if (lineCnt_q != LINE_MAX) begin
                            lineCnt_q <= lineCnt_q + LW'(1);
                        end
                        if (lineCnt_q == LINE_LAST) begin
                            state_q <= ST_WAIT_WR;
                        end
                    end
                end
                // Any new line before the writer finishes means the camera sent too much.
                ST_WAIT_WR: begin
                    if (write_done) begin
                        state_q    <= ST_IDLE;
                        busy       <= 1'b0;
                        frame_done <= (err == ERR_NONE);
                    end else if (hrefRise && (err == ERR_NONE)) begin
                        err <= ERR_LONG;
                    end
                end
                ST_ABORT: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 Parameter WIDTH, default 640, pixels per line.
REQ-002 Parameter HEIGHT, default 480, lines per frame.
REQ-003 Parameter Y_FIRST, default 1; 1 = luma byte is the first byte of each YUV422 byte pair, 0 = second byte.
REQ-004 HCLK  input  1  sole clock; all logic on its rising edge.
REQ-005 HRESET  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to capture one frame; ignored unless state IDLE.
REQ-007 cam_vsync  input  1  camera frame sync, high between frames.
REQ-008 cam_href  input  1  camera line valid, high while line bytes are present.
REQ-009 cam_data  input  8  camera byte, valid each cycle cam_href=1.
REQ-010 write_done  input  1  level from the BMP writer, high once it has received WIDTH*HEIGHT pixels.
REQ-011 pix_valid  output  1  one-cycle strobe per luma pixel; drives the writer's pixel-strobe (hsync) input.
REQ-012 pix_data  output  8  luma value, valid when pix_valid=1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_done  output  1  one-cycle pulse on a successful frame.
REQ-015 err  output  2  sticky error code: 0 none, 1 line length, 2 short frame, 3 long frame.

Function
REQ-016 States SHALL be IDLE, SYNC_HI, SYNC_LO, CAPTURE, WAIT_WR, ABORT.
REQ-017 IDLE -> SYNC_HI on start=1, clearing err, line and pixel counters.
REQ-018 SYNC_HI -> SYNC_LO on the first cycle cam_vsync=1; SYNC_LO -> CAPTURE on the first cycle cam_vsync=0 after that, so capture always begins at a full frame boundary.
REQ-019 In CAPTURE, a byte-phase bit SHALL reset to 0 on the cycle after cam_href=0 and toggle on every cam_href=1 cycle; a byte is luma when phase equals (Y_FIRST ? 0 : 1).
REQ-020 For each luma byte with line_cnt<HEIGHT and pix_cnt<WIDTH: pix_valid=1 and pix_data=cam_data one cycle later (latency 1, registered); pix_cnt increments.
REQ-021 Luma bytes beyond WIDTH in a line SHALL NOT produce pix_valid.
REQ-022 On the cam_href falling edge (registered href=1, current 0): if pix_cnt!=WIDTH set err=1 (first error only), pix_cnt<=0, line_cnt<=line_cnt+1.
REQ-023 When line_cnt reaches HEIGHT, CAPTURE -> WAIT_WR.
REQ-024 cam_vsync=1 in CAPTURE with line_cnt<HEIGHT: err=2, -> ABORT.
REQ-025 A cam_href rising edge in WAIT_WR before write_done: err=3 if err=0; no pix_valid emitted.
REQ-026 WAIT_WR -> IDLE when write_done=1; frame_done=1 for that one cycle only if err=0.
REQ-027 ABORT -> IDLE after one cycle; frame_done stays 0; err holds until next accepted start.
REQ-028 start while busy=1 SHALL be ignored with no effect on counters or err.
REQ-029 Counters SHALL be sized $clog2(WIDTH+1) and $clog2(HEIGHT+1) bits; they SHALL saturate and not wrap.
REQ-030 cam_href=1 while cam_vsync=1 SHALL be ignored.

Reset
REQ-031 HRESET=1 SHALL asynchronously force state IDLE, pix_valid=0, pix_data=0, busy=0, frame_done=0, err=0, all counters and phase bit 0.
REQ-032 HRESET asserted mid-frame SHALL abandon the frame; after release, no pix_valid until a new start and a full vsync cycle.

Structure
REQ-033 Shared package ov_cam_pkg SHALL hold the state enum, the err code constants, and the default WIDTH/HEIGHT.
REQ-034 One sub-module, sig_edge_det (registered rise/fall detect), SHALL be instantiated for cam_vsync and cam_href.
REQ-035 Implementation SHALL have no combinational path from any input to any output.

Verification
REQ-036 WIDTH=4, HEIGHT=2, Y_FIRST=1, start, vsync pulse, then 2 lines of bytes 10,80,11,81,...: exactly 8 pix_valid with data 10..17, one cycle after each luma byte; frame_done pulses when write_done rises; err=0.
REQ-037 Same setup, Y_FIRST=0: pix_data equals the second byte of each pair (80..87).
REQ-038 Line 1 carries only 3 pixel pairs: err=1, that line yields 3 pix_valid, and capture continues to WAIT_WR.
REQ-039 vsync rises after 1 of 2 lines: err=2, ABORT then IDLE, frame_done never asserts, busy falls 2 cycles later.
REQ-040 Start issued with cam_vsync already low mid-frame: no pix_valid until a vsync high->low sequence; start pulsed again while busy: no effect.
REQ-041 HRESET asserted during line 0 of CAPTURE: all outputs 0 immediately; a subsequent frame without start produces no pix_valid.
